// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with a skid buffer, flush and counters.
// Feeds MEM stage payload and the EX->EX forwarding tap.
module ex_mem_stage_reg #(
  parameter int DATA_W        = 32,
  parameter int RADDR_W       = 5,
  parameter int MTR_W         = 2,
  parameter int CNT_W         = 16,
  parameter int ZERO_REG_GATE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]  in_alu_out,
  input  logic [DATA_W-1:0]  in_pc_4,
  input  logic [DATA_W-1:0]  in_store_data,
  input  logic               in_memwrite,
  input  logic               in_memread,
  input  logic               in_regwrite,
  input  logic [MTR_W-1:0]   in_memtoreg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]  out_alu_out,
  output logic [DATA_W-1:0]  out_pc_4,
  output logic [DATA_W-1:0]  out_store_data,
  output logic               out_memwrite,
  output logic               out_memread,
  output logic               out_regwrite,
  output logic [MTR_W-1:0]   out_memtoreg,
  output logic               fwd_regwrite,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  pc_4;
    logic [DATA_W-1:0]  store_data;
    logic               memwrite;
    logic               memread;
    logic               regwrite;
    logic [MTR_W-1:0]   memtoreg;
  } beat_t;

  beat_t m_q;
  beat_t s_q;
  beat_t in_b;
  logic  m_valid;
  logic  s_valid;
  logic  fire_in;
  logic  advance;
  logic  rd_nz;

  // Clear the control bits so an invalid slot can never write anything.
  function automatic beat_t squash(input beat_t b);
    beat_t r;
    r          = b;
    r.memwrite = 1'b0;
    r.memread  = 1'b0;
    r.regwrite = 1'b0;
    r.memtoreg = '0;
    return r;
  endfunction

  // Pack the incoming EX beat.
  always_comb begin
    in_b            = '0;
    in_b.rd         = in_rd;
    in_b.alu_out    = in_alu_out;
    in_b.pc_4       = in_pc_4;
    in_b.store_data = in_store_data;
    in_b.memwrite   = in_memwrite;
    in_b.memread    = in_memread;
    in_b.regwrite   = in_regwrite;
    in_b.memtoreg   = in_memtoreg;
  end

  assign in_ready = !s_valid;
  assign fire_in  = in_valid & in_ready;
  assign advance  = !m_valid | out_ready;

  // Main and skid registers: flush, then drain/fill ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      s_q     <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_q     <= squash(m_q);
      s_q     <= squash(s_q);
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (advance) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (fire_in) begin
        m_q     <= in_b;
        m_valid <= 1'b1;
      end else begin
        m_q     <= squash(m_q);
        m_valid <= 1'b0;
      end
    end else if (fire_in) begin
      s_q     <= in_b;
      s_valid <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign out_valid      = m_valid;
  assign out_rd         = m_q.rd;
  assign out_alu_out    = m_q.alu_out;
  assign out_pc_4       = m_q.pc_4;
  assign out_store_data = m_q.store_data;
  assign out_memwrite   = m_q.memwrite;
  assign out_memread    = m_q.memread;
  assign out_regwrite   = m_q.regwrite;
  assign out_memtoreg   = m_q.memtoreg;

  assign rd_nz        = (ZERO_REG_GATE != 0) ? (m_q.rd != '0) : 1'b1;
  assign fwd_regwrite = m_valid & m_q.regwrite & rd_nz;
  assign fwd_rd       = m_q.rd;
  assign fwd_data     = m_q.alu_out;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: two configurations on shared stimulus,
// checked against a queue-based model of the stage.
module tb_ex_mem_stage_reg;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] sd;
    logic        mw;
    logic        mr;
    logic        rw;
    logic [1:0]  mtr;
  } beat_t;

  logic        clk = 0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_out, in_pc_4, in_store_data;
  logic        in_memwrite, in_memread, in_regwrite;
  logic [1:0]  in_memtoreg;

  logic        r0, v0, mw0, mr0, rw0, fw0;
  logic [4:0]  rd0, frd0;
  logic [31:0] alu0, pc0, sd0, fd0;
  logic [1:0]  mt0;
  logic [15:0] sc0, fc0;

  logic        r1, v1, mw1, mr1, rw1, fw1;
  logic [4:0]  rd1, frd1;
  logic [31:0] alu1, pc1, sd1, fd1;
  logic [1:0]  mt1;
  logic [3:0]  sc1, fc1;

  int n_chk = 0;
  int n_err = 0;

  beat_t q[$];
  beat_t shown;
  int    stall_c;
  int    flush_c;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r0),
    .in_rd(in_rd), .in_alu_out(in_alu_out),
    .in_pc_4(in_pc_4), .in_store_data(in_store_data),
    .in_memwrite(in_memwrite), .in_memread(in_memread),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .out_valid(v0), .out_ready(out_ready),
    .out_rd(rd0), .out_alu_out(alu0), .out_pc_4(pc0),
    .out_store_data(sd0), .out_memwrite(mw0),
    .out_memread(mr0), .out_regwrite(rw0),
    .out_memtoreg(mt0), .fwd_regwrite(fw0),
    .fwd_rd(frd0), .fwd_data(fd0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  ex_mem_stage_reg #(.CNT_W(4), .ZERO_REG_GATE(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r1),
    .in_rd(in_rd), .in_alu_out(in_alu_out),
    .in_pc_4(in_pc_4), .in_store_data(in_store_data),
    .in_memwrite(in_memwrite), .in_memread(in_memread),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .out_valid(v1), .out_ready(out_ready),
    .out_rd(rd1), .out_alu_out(alu1), .out_pc_4(pc1),
    .out_store_data(sd1), .out_memwrite(mw1),
    .out_memread(mr1), .out_regwrite(rw1),
    .out_memtoreg(mt1), .fwd_regwrite(fw1),
    .fwd_rd(frd1), .fwd_data(fd1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_reset();
    q.delete();
    shown   = '{default: '0};
    stall_c = 0;
    flush_c = 0;
  endtask

  // One clock edge of the stage, in terms of a FIFO of in-flight beats.
  task automatic model_clk();
    beat_t b;
    bit    fire;
    if (rst) return;
    if (q.size() > 0 && !out_ready) stall_c++;
    if (flush) begin
      q.delete();
      flush_c++;
    end else begin
      fire = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (fire) begin
        b.rd  = in_rd;
        b.alu = in_alu_out;
        b.pc4 = in_pc_4;
        b.sd  = in_store_data;
        b.mw  = in_memwrite;
        b.mr  = in_memread;
        b.rw  = in_regwrite;
        b.mtr = in_memtoreg;
        q.push_back(b);
      end
    end
    if (q.size() > 0) shown = q[0];
  endtask

  task automatic check_all();
    beat_t e;
    bit    vld;
    bit    f0, f1;
    vld = q.size() > 0;
    e   = vld ? q[0] : shown;
    if (!vld) begin
      e.mw  = 0;
      e.mr  = 0;
      e.rw  = 0;
      e.mtr = 0;
    end
    f1 = vld && e.rw;
    f0 = f1 && (e.rd != 0);
    chk("in_ready", {r1, r0}, {2{q.size() < 2}});
    chk("out_valid", {v1, v0}, {2{vld}});
    chk("out_rd", {rd1, rd0}, {e.rd, e.rd});
    chk("out_alu", {alu1, alu0}, {e.alu, e.alu});
    chk("out_pc4", {pc1, pc0}, {e.pc4, e.pc4});
    chk("out_sd", {sd1, sd0}, {e.sd, e.sd});
    chk("out_ctl", {mw1, mr1, rw1, mt1, mw0, mr0, rw0, mt0},
        {e.mw, e.mr, e.rw, e.mtr, e.mw, e.mr, e.rw, e.mtr});
    chk("fwd_rw", {fw1, fw0}, {f1, f0});
    chk("fwd_rd_data", {frd1, fd1, frd0, fd0},
        {e.rd, e.alu, e.rd, e.alu});
    chk("stall_cnt0", 64'(sc0), 64'(sat(stall_c, 16)));
    chk("stall_cnt1", 64'(sc1), 64'(sat(stall_c, 4)));
    chk("flush_cnt0", 64'(fc0), 64'(sat(flush_c, 16)));
    chk("flush_cnt1", 64'(fc1), 64'(sat(flush_c, 4)));
  endtask

  task automatic set_in(input logic v, input beat_t b);
    in_valid      = v;
    in_rd         = b.rd;
    in_alu_out    = b.alu;
    in_pc_4       = b.pc4;
    in_store_data = b.sd;
    in_memwrite   = b.mw;
    in_memread    = b.mr;
    in_regwrite   = b.rw;
    in_memtoreg   = b.mtr;
  endtask

  task automatic cyc(input logic v, input beat_t b,
                     input logic ordy, input logic fl);
    set_in(v, b);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_clk();
    @(negedge clk);
    check_all();
  endtask

  function automatic beat_t mk(input logic [4:0] rd,
                               input logic [31:0] alu,
                               input logic rw, input logic mw);
    beat_t b;
    b.rd  = rd;
    b.alu = alu;
    b.pc4 = alu + 32'h100;
    b.sd  = ~alu;
    b.mw  = mw;
    b.mr  = 1'b0;
    b.rw  = rw;
    b.mtr = 2'd1;
    return b;
  endfunction

  function automatic beat_t rnd();
    beat_t b;
    b.rd  = 5'($urandom_range(0, 31));
    b.alu = $urandom;
    b.pc4 = $urandom;
    b.sd  = $urandom;
    b.mw  = 1'($urandom);
    b.mr  = 1'($urandom);
    b.rw  = 1'($urandom);
    b.mtr = 2'($urandom);
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    set_in(1'b1, mk(5'd7, 32'h55, 1'b1, 1'b1));
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 0;
    check_all();
  endtask

  beat_t nb;

  initial begin
    nb = '{default: '0};
    rst = 1;
    flush = 0;
    out_ready = 1;
    set_in(1'b1, mk(5'd9, 32'h99, 1'b1, 1'b1));
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_in_ready", {r1, r0}, 2'b11);
    chk("rst_out_valid", {v1, v0}, 2'b00);
    chk("rst_alu", 64'(alu0), 64'h0);
    rst = 0;

    // Streaming back-to-back
    cyc(1, mk(5'd3, 32'h10, 1, 0), 1, 0);
    chk("stream_a", 64'(alu0), 64'h10);
    cyc(1, mk(5'd4, 32'h20, 1, 0), 1, 0);
    chk("stream_b", 64'(alu0), 64'h20);
    cyc(1, mk(5'd5, 32'h30, 1, 0), 1, 0);
    chk("stream_c", {fw0, rd0, alu0}, {1'b1, 5'd5, 32'h30});
    cyc(0, nb, 1, 0);
    chk("stream_bubble", {v0, rw0}, 2'b00);

    // Backpressure fills the skid buffer
    cyc(1, mk(5'd6, 32'h11, 1, 0), 0, 0);
    cyc(1, mk(5'd7, 32'h22, 1, 0), 0, 0);
    chk("skid_full", {r0, alu0}, {1'b0, 32'h11});
    cyc(1, mk(5'd8, 32'h33, 1, 0), 0, 0);
    cyc(0, nb, 1, 0);
    chk("skid_drain_b", 64'(alu0), 64'h22);
    cyc(0, nb, 1, 0);
    chk("skid_bubble", 64'(v0), 64'h0);

    // Flush with a store in M, skid valid and a beat incoming
    do_reset();
    cyc(1, mk(5'd1, 32'hA0, 0, 1), 0, 0);
    cyc(1, mk(5'd2, 32'hB0, 1, 0), 0, 0);
    cyc(1, mk(5'd3, 32'hC0, 1, 0), 0, 1);
    chk("flush_state", {v0, mw0, r0}, 3'b001);
    chk("flush_cnt_1", 64'(fc0), 64'h1);
    cyc(0, nb, 1, 0);
    chk("flush_dropped", 64'(v0), 64'h0);

    // Zero register write: gated only when ZERO_REG_GATE=1
    cyc(1, mk(5'd0, 32'hDEAD, 1, 0), 1, 0);
    chk("zreg_gate", {rw0, fw0, fw1}, 3'b101);

    // Counter saturation on the 4-bit instance
    do_reset();
    cyc(1, mk(5'd4, 32'h44, 1, 0), 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, rnd(), 0, 0);
    chk("stall_sat", {sc1, sc0}, {4'hF, 16'd20});
    for (int i = 0; i < 18; i++) cyc(0, nb, 0, 1);
    chk("flush_sat", {fc1, fc0}, {4'hF, 16'd18});

    // Reset in the middle of a stall: both beats lost at once
    cyc(1, mk(5'd5, 32'h55, 1, 1), 0, 0);
    cyc(1, mk(5'd6, 32'h66, 1, 1), 0, 0);
    do_reset();
    chk("midstall_rst", {v0, alu0, r0}, {1'b0, 32'h0, 1'b1});

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), rnd(),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 29) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline stage register; the next generation of the fixed 32-bit EX/MEM latch.
- Adds ready/valid handshaking with a one-entry skid buffer, synchronous flush (bubble insertion), a valid-gated forwarding tap and saturating stall/flush performance counters.
- Sits between the ALU/operand-B mux (EX) and data memory/writeback control (MEM).

Parameters:
DATA_W, 32, width of ALU result, PC+4 and store-data fields
RADDR_W, 5, register-file address width
MTR_W, 2, MemtoReg select width
CNT_W, 16, width of each performance counter
ZERO_REG_GATE, 1, 1 = writes to register 0 never assert fwd_regwrite

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous flush; squashes stage contents
in_valid  in  1  EX beat valid
in_ready  out  1  stage can accept a beat
in_rd  in  RADDR_W  destination register
in_alu_out  in  DATA_W  ALU result / memory address
in_pc_4  in  DATA_W  PC+4 of instruction
in_store_data  in  DATA_W  forwarded operand B for stores
in_memwrite, in_memread, in_regwrite  in  1 each  control bits
in_memtoreg  in  MTR_W  writeback select
out_valid  out  1  MEM beat valid
out_ready  in  1  MEM accepts beat
out_rd, out_alu_out, out_pc_4, out_store_data, out_memwrite, out_memread, out_regwrite, out_memtoreg  out  matching  registered payload
fwd_regwrite  out  1  out_valid & out_regwrite (& out_rd!=0 if ZERO_REG_GATE)
fwd_rd  out  RADDR_W  equals out_rd
fwd_data  out  DATA_W  equals out_alu_out
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
flush_cnt  out  CNT_W  flush assertions

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. rst clears all state: main and skid registers all zero, both valid bits 0, counters 0. in_ready=1 during/after reset.
- Storage: main register M (drives out_*) and skid register S, each with its own valid bit.
- in_ready = !S_valid, registered and never combinationally dependent on out_ready. fire_in = in_valid & in_ready.
- advance = !M_valid | out_ready.
- Priority 1, flush: M_valid<=0, S_valid<=0; control bits of M and S (memwrite, memread, regwrite, memtoreg) <=0. Data fields hold. The incoming beat in the same cycle is dropped. rst overrides flush.
- Priority 2, advance with S_valid: M<=S, S_valid<=0.
- Priority 2, advance without S_valid: on fire_in, M<=in and M_valid<=1. Otherwise M_valid<=0, M controls <=0, M data holds (bubble).
- Priority 2, no advance: on fire_in, S<=in and S_valid<=1. M holds.
- Latency 1 cycle EX to MEM when unstalled; throughput 1 beat/cycle; beats never reordered, duplicated or lost except by flush.
- out_memwrite, out_memread and out_regwrite are 0 whenever out_valid=0 (guaranteed by control zeroing).
- stall_cnt: +1 each cycle with out_valid & !out_ready. flush_cnt: +1 each cycle flush=1. Both saturate at all-ones and do not wrap; cleared only by rst.
- Reset asserted mid-stall: both beats lost; outputs zero on the same edge (asynchronous).

Test Plan:
- Reset: assert rst with in_valid=1 -> all out_* =0, out_valid=0, in_ready=1, counters 0.
- Streaming: out_ready=1, feed ALU=0x10,0x20,0x30 with rd=3,4,5 and regwrite=1 on consecutive cycles -> same values appear on out_* one cycle later, back-to-back; fwd_regwrite=1 each cycle.
- Backpressure/skid: hold out_ready=0 while feeding A=0x11, B=0x22 -> M=A, S=B, in_ready=0 next cycle, stall_cnt increments per stalled cycle. Release out_ready -> A then B, then a bubble.
- Flush: M holds a store (memwrite=1), S valid, in_valid=1, assert flush for one cycle -> out_valid=0, out_memwrite=0, in_ready=1, incoming beat absent, flush_cnt=1.
- Zero register: regwrite=1, rd=0, alu=0xDEAD with ZERO_REG_GATE=1 -> out_regwrite=1 but fwd_regwrite=0. With ZERO_REG_GATE=0 -> fwd_regwrite=1.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt reaches 15 and stays at 15.
